// File: rtl/skid_crd_pipe.sv
// skid_crd_pipe: credit-controlled AXI-Stream skid buffer.
//
// Accepted beats pass through LAT register stages and land in a DEPTH-entry
// first-word-fall-through circular store. in_tready is a registered function
// of a credit counter (one credit per store entry). That keeps the upstream
// ready path fully registered and still lets no beat be lost, whatever LAT is.
//
// Ports:
//   aclk        clock
//   aresetn     asynchronous active-low reset
//   in_tdata    upstream data (NB bits)
//   in_tvalid   upstream valid
//   in_tready   registered; high while at least one credit is held
//   out_tdata   data at the head of the store
//   out_tvalid  store not empty
//   out_tready  downstream ready
//   crd_cnt     free credits (0..DEPTH)
//   level       entries currently held in the store (0..DEPTH)
//   err_ovf     sticky; set by a write into a full store with no read
module skid_crd_pipe #(
   parameter int unsigned N     = 5,
   parameter int unsigned NB    = N * 8,
   parameter int unsigned LAT   = 1,
   parameter int unsigned DEPTH = 4
) (
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic [NB-1:0]                in_tdata,
   input  logic                         in_tvalid,
   output logic                         in_tready,
   output logic [NB-1:0]                out_tdata,
   output logic                         out_tvalid,
   input  logic                         out_tready,
   output logic [$clog2(DEPTH+1)-1:0]   crd_cnt,
   output logic [$clog2(DEPTH+1)-1:0]   level,
   output logic                         err_ovf
);

   localparam int unsigned CW = $clog2(DEPTH + 1);
   localparam int unsigned PW = $clog2(DEPTH);

   if (LAT < 1 || LAT > 8) begin : g_bad_lat
      $error("skid_crd_pipe: LAT must be in 1..8");
   end
   if (DEPTH < 2 || DEPTH > 64) begin : g_bad_depth
      $error("skid_crd_pipe: DEPTH must be in 2..64");
   end
   if (DEPTH < LAT + 1) begin : g_bad_ratio
      $error("skid_crd_pipe: DEPTH must be >= LAT+1");
   end

   logic [CW-1:0]   crd_q, crd_d;
   logic            in_tready_q;
   logic [LAT-1:0]  pvld_q, pvld_d;
   logic [NB-1:0]   pdata_q [LAT];
   logic [NB-1:0]   mem_q [DEPTH];
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;
   logic [CW-1:0]   level_q, level_d;
   logic            err_q, err_d;

   logic            wr, rd, st_wr, st_ok, full;

   assign out_tvalid = (level_q != '0);
   assign wr         = in_tvalid & in_tready_q;
   assign rd         = out_tvalid & out_tready;
   assign st_wr      = pvld_q[LAT-1];
   assign full       = (level_q == CW'(DEPTH));
   // A write into a full store is fine when the head leaves on the same edge.
   assign st_ok      = st_wr & (~full | rd);

   always_comb begin
      pvld_d    = '0;
      pvld_d[0] = wr;
      for (int i = 1; i < int'(LAT); i++) begin
         pvld_d[i] = pvld_q[i-1];
      end
   end

   always_comb begin
      crd_d = crd_q;
      unique case ({wr, rd})
         2'b10:   crd_d = crd_q - CW'(1);
         2'b01:   crd_d = crd_q + CW'(1);
         default: crd_d = crd_q;
      endcase
   end

   always_comb begin
      level_d = level_q;
      unique case ({st_ok, rd})
         2'b10:   level_d = level_q + CW'(1);
         2'b01:   level_d = level_q - CW'(1);
         default: level_d = level_q;
      endcase
   end

   always_comb begin
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      if (st_ok) begin
         wptr_d = (wptr_q == PW'(DEPTH - 1)) ? '0 : wptr_q + PW'(1);
      end
      if (rd) begin
         rptr_d = (rptr_q == PW'(DEPTH - 1)) ? '0 : rptr_q + PW'(1);
      end
   end

   assign err_d = err_q | (st_wr & full & ~rd);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         crd_q       <= CW'(DEPTH);
         in_tready_q <= 1'b0;
         pvld_q      <= '0;
         wptr_q      <= '0;
         rptr_q      <= '0;
         level_q     <= '0;
         err_q       <= 1'b0;
      end else begin
         crd_q       <= crd_d;
         // Registered from the next credit count so ready never sees out_tready.
         in_tready_q <= (crd_d != '0);
         pvld_q      <= pvld_d;
         wptr_q      <= wptr_d;
         rptr_q      <= rptr_d;
         level_q     <= level_d;
         err_q       <= err_d;
      end
   end

   // Data path: no reset, qualified by the valid bits and pointers above.
   always_ff @(posedge aclk) begin
      if (wr) begin
         pdata_q[0] <= in_tdata;
      end
      for (int i = 1; i < int'(LAT); i++) begin
         pdata_q[i] <= pdata_q[i-1];
      end
      if (st_ok) begin
         mem_q[wptr_q] <= pdata_q[LAT-1];
      end
   end

   assign in_tready = in_tready_q;
   assign out_tdata = mem_q[rptr_q];
   assign crd_cnt   = crd_q;
   assign level     = level_q;
   assign err_ovf   = err_q;

endmodule

// File: doc/skid_crd_pipe.md
Name: skid_crd_pipe

Overview:
- Credit-controlled AXI-Stream skid buffer, parametrised in data width, input pipeline latency and storage depth.
- Accepted beats travel through LAT register stages into a DEPTH-entry first-word-fall-through store. in_tready is driven by a credit counter, so no beat is ever dropped, whatever the pipeline latency.
- Sits between cascaded stream stages whose ready path must stay fully registered.
- Exports credit and fill status for monitoring, plus a sticky overflow error flag.

Parameters:
- N, 5, data width in bytes
- NB, N*8, data width in bits
- LAT, 1, number of input register stages between acceptance and storage; legal range 1..8
- DEPTH, 4, storage entries, which also equals the credit count; legal range 2..64, any value (power of 2 not required); must satisfy DEPTH >= LAT+1, checked at elaboration with $error

Ports:
- aclk, input, 1, clock
- aresetn, input, 1, asynchronous active-low reset
- in_tdata, input, NB, upstream data
- in_tvalid, input, 1, upstream valid
- in_tready, output, 1, registered; high when at least one credit is held
- out_tdata, output, NB, head-of-store data
- out_tvalid, output, 1, store not empty
- out_tready, input, 1, downstream ready
- crd_cnt, output, $clog2(DEPTH+1), free credits
- level, output, $clog2(DEPTH+1), entries currently in the store
- err_ovf, output, 1, sticky; write into a full store

Behaviour:
- Handshake events:
  - wr = in_tvalid & in_tready
  - rd = out_tvalid & out_tready
  - Both are evaluated at the rising edge of aclk.
- Reset (aresetn low, asynchronous):
  - in_tready=0, out_tvalid=0, crd_cnt=DEPTH, level=0, err_ovf=0.
  - All pipeline valid bits cleared; read and write pointers at 0.
  - Data registers are not reset.
  - in_tready rises at the first aclk edge after deassertion.
  - A reset mid-operation discards all in-flight and stored beats.
- Credit counter:
  - wr only: decrement. rd only: increment. Both or neither: hold.
  - in_tready is registered as (next crd_cnt != 0), so it never depends combinationally on out_tready.
  - crd_cnt never leaves the range 0..DEPTH.
- Pipeline:
  - Stage 1 captures in_tdata and wr at the edge where wr occurs.
  - Each following stage shifts one per edge.
  - The last stage writes the store when its valid bit is set.
  - A beat accepted at edge k is written at edge k+LAT.
  - out_tvalid is high from edge k+LAT onward if the store was empty.
- Latency and throughput:
  - Minimum in-to-out latency is LAT+1 cycles, no bypass.
  - Sustained throughput is 1 beat per cycle when out_tready is held high.
- Store:
  - Circular buffer of DEPTH entries; the write pointer wraps from DEPTH-1 to 0, and so does the read pointer.
  - out_tdata is the entry at the read pointer.
  - out_tdata and out_tvalid are stable while out_tvalid=1 and out_tready=0.
  - level increments on a store write, decrements on rd, and holds when both occur.
  - Writing into an empty store while rd is impossible (out_tvalid=0) is legal.
- Simultaneous write and read with the store full (level=DEPTH): legal, level holds.
- Error:
  - A store write while level=DEPTH with no rd in the same cycle sets err_ovf and drops the beat.
  - This is unreachable by construction; verification asserts err_ovf never rises.
- Invariant: crd_cnt + level + (in-flight pipeline beats) == DEPTH at every edge.
- in_tvalid while in_tready=0 has no effect. Upstream must hold data and valid until accepted (AXI rule).

Test Plan:
- Reset then idle, DEPTH=4, LAT=1:
  - During reset: in_tready=0, crd_cnt=4, level=0, out_tvalid=0.
  - One edge after release: in_tready=1.
- Single beat 0x0102030405 at edge k with out_tready=1:
  - out_tvalid rises after edge k+1 and falls after one cycle.
  - crd_cnt sequence 4→3→4.
- out_tready=0, 6 beats offered back-to-back:
  - Exactly 4 accepted; in_tready falls after the 4th; level reaches 4.
  - Releasing out_tready yields the 4 beats in order, then the remaining 2.
  - err_ovf stays 0.
- Streaming, LAT=3, DEPTH=4, 100 incrementing beats:
  - Output in order, 1 beat per cycle after a 4-cycle latency; no bubbles.
- Random in_tvalid/out_tready (50%), 1000 beats, DEPTH=5 (non-power-of-2, so pointer wrap is exercised):
  - Order preserved; conservation invariant holds every cycle.
- Reset asserted asynchronously with level=3 and 1 beat in flight:
  - All outputs reach their reset values immediately.
  - No stale beat appears after release.
